// File: rtl/keccak_pkg.sv
// Keccak state types, lane constants and the lane-index to (x,y) mapping.
package keccak_pkg;

    localparam int unsigned N         = 64;
    localparam int unsigned NUM_LANES = 25;

    typedef logic [N-1:0]        lane_t;
    typedef lane_t [4:0]         plane;
    typedef plane  [4:0]         state;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } lane_xy_t;

    // Lane k sits at A[x][y] with k = 5*x + y.
    function automatic lane_xy_t lane_to_xy(input logic [4:0] k);
        lane_xy_t r;
        r.x = 3'(k / 5'd5);
        r.y = 3'(k % 5'd5);
        return r;
    endfunction

endpackage

// File: rtl/lane_word_mux.sv
// Selects beat i_beat of lane i_lane from a Keccak state.
// STATE_SERIALIZER_BSWAP_EN: byte-reverse the selected word.
module lane_word_mux
    import keccak_pkg::*;
#(
    parameter int unsigned OUT_W  = 64,
    parameter int unsigned BEAT_W = 1
) (
    input  state              i_state,
    input  logic [4:0]        i_lane,
    input  logic [BEAT_W-1:0] i_beat,
    output logic [OUT_W-1:0]  o_word
);

    lane_xy_t         w_xy;
    lane_t            w_lane_word;
    logic [OUT_W-1:0] w_beat_word;

    always_comb begin
        w_xy        = lane_to_xy(i_lane);
        w_lane_word = i_state[w_xy.x][w_xy.y];
        w_beat_word = w_lane_word[i_beat*OUT_W +: OUT_W];
    end

`ifdef STATE_SERIALIZER_BSWAP_EN
    always_comb begin
        o_word = '0;
        for (int b = 0; b < OUT_W / 8; b++) begin
            o_word[b*8 +: 8] = w_beat_word[(OUT_W/8 - 1 - b)*8 +: 8];
        end
    end
`else
    assign o_word = w_beat_word;
`endif

endmodule

// File: rtl/state_serializer.sv
// Serialises a captured Keccak state lane by lane into OUT_W-bit words.
// STATE_SERIALIZER_BSWAP_EN selects byte-reversed output words.
module state_serializer
    import keccak_pkg::*;
#(
    parameter int unsigned OUT_W     = 64,
    parameter int unsigned MAX_LANES = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  state             A,
    input  logic [4:0]       num_lanes,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned BEATS  = N / OUT_W;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LANE_W = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1;

    typedef enum logic {StIdle, StSend} st_e;

    st_e               r_st;
    state              r_A;
    logic [LANE_W-1:0] r_lane;
    logic [LANE_W-1:0] r_last_lane;
    logic [BEAT_W-1:0] r_beat;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_busy;
    logic              r_in_ready;

    logic [LANE_W-1:0] w_last_lane_in;
    logic              w_beat_wrap;
    logic [BEAT_W-1:0] w_next_beat;
    logic [LANE_W-1:0] w_next_lane;
    logic              w_next_last;
    logic              w_first_last;
    logic [OUT_W-1:0]  w_word;

    // Out-of-range or zero lane requests fall back to a full MAX_LANES transfer.
    always_comb begin
        if (num_lanes == 5'd0 || 32'(num_lanes) > MAX_LANES) begin
            w_last_lane_in = LANE_W'(MAX_LANES - 1);
        end else begin
            w_last_lane_in = LANE_W'(num_lanes - 5'd1);
        end
        w_first_last = (w_last_lane_in == '0) && (BEATS == 1);
    end

    always_comb begin
        w_beat_wrap = (r_beat == BEAT_W'(BEATS - 1));
        w_next_beat = w_beat_wrap ? '0 : r_beat + 1'b1;
        w_next_lane = w_beat_wrap ? r_lane + 1'b1 : r_lane;
        w_next_last = (w_next_lane == r_last_lane) && (w_next_beat == BEAT_W'(BEATS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st        <= StIdle;
            r_lane      <= '0;
            r_beat      <= '0;
            r_last_lane <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            unique case (r_st)
                StIdle: begin
                    if (in_valid) begin
                        r_A         <= A;
                        r_last_lane <= w_last_lane_in;
                        r_lane      <= '0;
                        r_beat      <= '0;
                        r_st        <= StSend;
                        r_out_valid <= 1'b1;
                        r_out_last  <= w_first_last;
                        r_busy      <= 1'b1;
                        r_in_ready  <= 1'b0;
                    end
                end
                StSend: begin
                    if (out_ready) begin
                        if (r_out_last) begin
                            r_st        <= StIdle;
                            r_lane      <= '0;
                            r_beat      <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_in_ready  <= 1'b1;
                        end else begin
                            r_lane     <= w_next_lane;
                            r_beat     <= w_next_beat;
                            r_out_last <= w_next_last;
                        end
                    end
                end
                default: r_st <= StIdle;
            endcase
        end
    end

    lane_word_mux #(
        .OUT_W  (OUT_W),
        .BEAT_W (BEAT_W)
    ) u_mux (
        .i_state (r_A),
        .i_lane  (5'(r_lane)),
        .i_beat  (r_beat),
        .o_word  (w_word)
    );

    // Data is forced to zero outside SEND so reset and idle present a clean bus.
    assign out_data  = r_out_valid ? w_word : '0;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign in_ready  = r_in_ready;

endmodule

// File: tb/tb_state_serializer.sv
// Scoreboard bench for state_serializer: a lane/beat list model feeds a queue checked by a monitor.
module tb_state_serializer;
    import keccak_pkg::*;

    parameter int unsigned OUT_W     = 64;
    localparam int unsigned MAX_LANES = 25;
    localparam int unsigned BEATS     = 64 / OUT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    state             A;
    logic [4:0]       num_lanes;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;

    int n_chk  = 0;
    int n_fail = 0;
    int rdy_mode;

    logic [63:0] exp_data_q[$];
    logic        exp_last_q[$];

    state_serializer #(
        .OUT_W     (OUT_W),
        .MAX_LANES (MAX_LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .num_lanes (num_lanes),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] bswap(input logic [63:0] w);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < OUT_W / 8; b++) r[b*8 +: 8] = w[(OUT_W/8 - 1 - b)*8 +: 8];
        return r;
    endfunction

    // Reference: flatten lanes in k order, split each into beats low bits first.
    function automatic void push_expected(input state a, input logic [4:0] n);
        int          cnt;
        logic [63:0] lane_v;
        logic [63:0] w;
        logic [63:0] mask;
        mask = {64{1'b1}} >> (64 - OUT_W);
        cnt  = (n == 0 || n > MAX_LANES) ? MAX_LANES : int'(n);
        for (int k = 0; k < cnt; k++) begin
            lane_v = a[k/5][k%5];
            for (int j = 0; j < BEATS; j++) begin
                w = (lane_v >> (j * OUT_W)) & mask;
`ifdef STATE_SERIALIZER_BSWAP_EN
                w = bswap(w);
`endif
                exp_data_q.push_back(w);
                exp_last_q.push_back(k == cnt - 1 && j == BEATS - 1);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_data_q.delete();
            exp_last_q.delete();
        end else begin
            if (in_valid && in_ready) push_expected(A, num_lanes);
            if (out_valid) begin
                chk("send_flags", {62'd0, busy, in_ready}, 64'd2);
                if (exp_data_q.size() == 0) begin
                    chk("spurious_word", 64'(out_data), 64'hx);
                end else begin
                    chk("data", 64'(out_data), exp_data_q[0]);
                    chk("last", 64'(out_last), 64'(exp_last_q[0]));
                    if (out_ready) begin
                        void'(exp_data_q.pop_front());
                        void'(exp_last_q.pop_front());
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rdy_mode == 1) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic state rand_state();
        state s;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) s[x][y] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    endtask

    // Returns just after the accepting edge; the first word is then visible.
    task automatic start(input state a, input logic [4:0] n);
        int i;
        A         = a;
        num_lanes = n;
        in_valid  = 1'b1;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("start_timeout", 64'(i < 50), 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        A         = rand_state();
        num_lanes = 5'($urandom_range(0, 31));
    endtask

    task automatic run_fixed(input string tag, input int exp_cycles);
        int cyc;
        cyc = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!out_valid) break;
            cyc++;
        end
        chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cycles));
        check_idle(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && exp_data_q.size() == 0) break;
        end
        chk("idle_timeout", 64'(i < 3000), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        state a;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        num_lanes = '0;
        A         = '0;
        rdy_mode  = 2;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) a[x][y] = 64'(10 * x + y);
        start(a, 5'd4);
        run_fixed("four_lanes", 4 * BEATS);

        start(rand_state(), 5'd0);
        run_fixed("zero_lanes", 25 * BEATS);

        start(rand_state(), 5'd31);
        run_fixed("over_max", 25 * BEATS);

        start(rand_state(), 5'd1);
        run_fixed("one_lane", BEATS);

        // Stall pattern 1,0,0,1 while words are in flight.
        start(rand_state(), 5'd6);
        out_ready = 1'b1; @(posedge clk); #1;
        out_ready = 1'b0; @(posedge clk); #1;
        out_ready = 1'b0; @(posedge clk); #1;
        out_ready = 1'b1; @(posedge clk); #1;
        wait_idle();

        // Reset while the third word of a 17-lane transfer is presented.
        start(rand_state(), 5'd17);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("mid_reset");
        @(posedge clk); #1;
        start(rand_state(), 5'd3);
        wait_idle();

        rdy_mode = 1;
        for (int t = 0; t < 20; t++) begin
            start(rand_state(), 5'($urandom_range(0, 31)));
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rdy_mode = 2;
        chk("queue_drained", 64'(exp_data_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/state_serializer.md
STATE_SERIALIZER -- requirements
Module: state_serializer

Interface
REQ-001 Parameter OUT_W, default 64: output word width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter MAX_LANES, default 25: upper bound on lanes emitted per transfer.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  a state is offered for serialisation.
REQ-006 in_ready  output  1  block accepts a state this cycle.
REQ-007 A  input  keccak_pkg::state  5x5 array of 64-bit lanes.
REQ-008 num_lanes  input  5  lanes to emit, sampled with A.
REQ-009 out_data  output  OUT_W  current output word.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  sink accepts out_data.
REQ-012 out_last  output  1  final word of the transfer.
REQ-013 busy  output  1  transfer in progress.

Function
REQ-014 The FSM SHALL have two states: IDLE and SEND.
REQ-015 in_ready SHALL equal 1 only in IDLE; busy SHALL equal 1 only in SEND.
REQ-016 In IDLE, in_valid=1 SHALL capture A into an internal state register, capture the effective lane count, and enter SEND on the next cycle.
REQ-017 Effective lane count SHALL be num_lanes when 1..MAX_LANES, and MAX_LANES when num_lanes is 0 or greater than MAX_LANES.
REQ-018 Lane order SHALL be k = 5*x + y for A[x][y], so lane 0 = A[0][0], lane 1 = A[0][1], lane 5 = A[1][0], lane 24 = A[4][4].
REQ-019 Each lane SHALL be emitted in BEATS = 64/OUT_W words, beat j carrying lane bits [j*OUT_W +: OUT_W], lowest bits first.
REQ-020 In SEND, out_valid SHALL be 1; a beat advances only when out_valid and out_ready are both 1.
REQ-021 out_data and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 out_last SHALL be 1 exactly on beat BEATS-1 of lane (effective count - 1).
REQ-023 Acceptance of the out_last word SHALL return the FSM to IDLE on the next cycle; at least one IDLE cycle separates transfers.
REQ-024 Changes to A or num_lanes during SEND SHALL have no effect.
REQ-025 The first word SHALL appear on out_valid one cycle after the in_valid/in_ready handshake; with out_ready held at 1, the transfer SHALL take exactly count*BEATS cycles.
REQ-026 The lane and beat counters SHALL be sized for MAX_LANES and BEATS, and SHALL clear on IDLE entry.

Reset
REQ-027 rst=1 SHALL force IDLE, out_valid=0, out_last=0, busy=0, in_ready=1 (from the following cycle), out_data=0, and clear the counters.
REQ-028 Reset during SEND SHALL abandon the transfer without emitting further words; the captured state need not be cleared.

Configuration
REQ-029 Macro STATE_SERIALIZER_BSWAP_EN defined: out_data SHALL be the byte-reversed beat word (OUT_W >= 16; for OUT_W = 8 it is unchanged).
REQ-030 Macro STATE_SERIALIZER_BSWAP_EN undefined: out_data SHALL be the beat word unchanged; the timing and handshake behaviour SHALL be identical in both builds.

Structure
REQ-031 keccak_pkg SHALL hold the state/plane types, N=64, and the new constants NUM_LANES=25 and the lane-index-to-(x,y) mapping function.
REQ-032 The FSM and counters SHALL reside in state_serializer; word selection SHALL be one sub-module, lane_word_mux (state, lane, beat -> word).

Verification
REQ-033 OUT_W=64, num_lanes=4, A[x][y]=64'h(10*x+y), out_ready=1 -> 4 words 0x00,0x01,0x02,0x03 on consecutive cycles, out_last on the 4th word, busy deasserted after it.
REQ-034 OUT_W=32, num_lanes=1, A[0][0]=64'hAAAA_BBBB_CCCC_DDDD -> words 0xCCCCDDDD then 0xAAAABBBB, out_last on the 2nd word.
REQ-035 num_lanes=0, OUT_W=64 -> 25 words, word 24 = A[4][4], out_last on word 24.
REQ-036 out_ready toggled 1,0,0,1 mid-transfer -> out_data/out_last held during stall, no word dropped or duplicated, in_ready=0 throughout.
REQ-037 rst pulsed during the 3rd word of a 17-lane transfer -> out_valid=0 the next cycle, in_ready=1, a new transfer then starts from lane 0.
REQ-038 STATE_SERIALIZER_BSWAP_EN build, OUT_W=32, A[0][0]=64'h0011_2233_4455_6677 -> words 0x77665544, 0x33221100.
